cgra_config_loader: RTL and testbench
=====================================

CGRA_CONFIG_LOADER -- requirements
Module: cgra_config_loader

Interface
REQ-001 Parameter PE_NUM, default 16: number of PEs served; write strobes one-hot over PE_NUM.
REQ-002 Parameter PE_ID_BIT_LENGTH, default 4: clog2(PE_NUM), width of cfg_pe_id.
REQ-003 Parameter ITERATION_BIT_LENGTH, default 16: width of cmd_iterations and iteration counter.
REQ-004 DATA_WIDTH, CONTEXT_SIZE, CONTEXT_SIZE_BIT_LENGTH, NEIGHBOR_PE_NUM_BIT_LENGTH, OPERATION_BIT_LENGTH and CONTEXT_SWITCH_CLK_SIZE SHALL come from the shared parameter package, not module parameters.
REQ-005 Ports, listed as name, direction, width, meaning:
  clk  in  1  single clock, all logic on rising edge.
  reset  in  1  synchronous, active-high reset.
  cfg_valid  in  1  config record offered.
  cfg_ready  out  1  loader accepts record this cycle.
  cfg_pe_id  in  PE_ID_BIT_LENGTH  target PE.
  cfg_context_id  in  CONTEXT_SIZE_BIT_LENGTH  target context slot.
  cfg_input_PE_index_1 / cfg_input_PE_index_2  in  NEIGHBOR_PE_NUM_BIT_LENGTH  operand selects.
  cfg_op  in  OPERATION_BIT_LENGTH  opcode.
  cfg_const_data  in  DATA_WIDTH  constant.
  cmd_start  in  1  run request.
  cmd_context_max_id  in  CONTEXT_SIZE_BIT_LENGTH  last context of mapping.
  cmd_iterations  in  ITERATION_BIT_LENGTH  full context loops to run.
  config_input_PE_index_1 / config_input_PE_index_2 / config_op / config_const_data / config_index  out  same widths  broadcast config fields to all PEs.
  write_config_data  out  PE_NUM  one-hot per-PE write strobe.
  start_exec  out  1  broadcast context reset.
  mapping_context_max_id  out  CONTEXT_SIZE_BIT_LENGTH  broadcast max context.
  busy  out  1  run in progress.
  done  out  1  one-cycle run-complete pulse.
  cfg_error  out  1  sticky bad-record flag.
  run_context_id  out  CONTEXT_SIZE_BIT_LENGTH  context the PEs currently execute.
  run_iteration  out  ITERATION_BIT_LENGTH  completed loops.

Function
REQ-006 States: IDLE, START, RUN, DONE; Moore outputs, all outputs registered except cfg_ready.
REQ-007 cfg_ready SHALL be (state==IDLE) && !cmd_start; a record transfers when cfg_valid && cfg_ready.
REQ-008 Accepted record at cycle N SHALL drive the config fields and config_index=cfg_context_id in N+1, with write_config_data bit cfg_pe_id high for exactly one cycle (N+1).
REQ-009 Record with cfg_context_id >= CONTEXT_SIZE or cfg_pe_id >= PE_NUM SHALL be consumed without any strobe and set cfg_error until reset.
REQ-010 cmd_start in IDLE SHALL latch cmd_context_max_id and cmd_iterations; cmd_start outside IDLE SHALL be ignored.
REQ-011 IDLE with cmd_start and cmd_iterations!=0 -> START; with cmd_iterations==0 -> DONE, no start_exec.
REQ-012 START: start_exec=1 and mapping_context_max_id=latched value for exactly one cycle; -> RUN.
REQ-013 RUN: slot timer counts 0..CONTEXT_SWITCH_CLK_SIZE, starting at 0 in the first RUN cycle; on wrap, run_context_id increments, going to 0 after latched max id.
REQ-014 RUN: each wrap of run_context_id from max id to 0 SHALL increment run_iteration; when it equals the latched count -> DONE.
REQ-015 RUN length SHALL be iterations*(max_id+1)*(CONTEXT_SWITCH_CLK_SIZE+1) cycles.
REQ-016 busy=1 in START and RUN only.
REQ-017 DONE: done=1 for one cycle; -> IDLE; run_iteration holds its final value until next start.
REQ-018 mapping_context_max_id SHALL hold the latched value after START until the next accepted cmd_start.

Reset
REQ-019 reset SHALL force IDLE and clear every output, counter and latched command to 0, including mid-RUN; no done pulse.
REQ-020 A record offered during reset SHALL NOT be accepted (cfg_ready=0 while reset=1).

Structure
REQ-021 State enum and the config-record struct SHALL live in the shared package next to ConfigData.
REQ-022 One sub-module, cgra_context_timer (slot timer, context counter, iteration counter), is natural; FSM and config path stay in the top.

Verification
REQ-023 Record pe=5, ctx=2, op=1, idx1=0, idx2=3, cfg_valid held 1 cycle -> next cycle write_config_data=16'h0020, config_index=2, config_op=1; one pulse only.
REQ-024 cmd_start with max_id=2, iterations=3 and CONTEXT_SWITCH_CLK_SIZE=3 -> start_exec 1 cycle, busy for 1+36 cycles, done 1 cycle, run_iteration=3.
REQ-025 cfg_valid and cmd_start in the same IDLE cycle -> cfg_ready=0, record held; it is accepted on the first cycle back in IDLE after done.
REQ-026 cmd_iterations=0 -> no start_exec, done pulses 1 cycle after cmd_start, busy never high.
REQ-027 reset asserted mid-RUN at context 1 -> next cycle state IDLE, all outputs 0, no done pulse; cmd_start then runs normally.
REQ-028 PE_NUM=12, record pe=13 -> no strobe, cfg_error=1 until reset.

Source files
------------

// File: rtl/cgra_config_loader_pkg.sv
// Shared parameters, FSM state type and config-record types for the CGRA config loader.
package cgra_config_loader_pkg;

  localparam int unsigned DATA_WIDTH                 = 16;
  localparam int unsigned CONTEXT_SIZE               = 6;
  localparam int unsigned CONTEXT_SIZE_BIT_LENGTH    = 3;
  localparam int unsigned NEIGHBOR_PE_NUM_BIT_LENGTH = 2;
  localparam int unsigned OPERATION_BIT_LENGTH       = 4;
  localparam int unsigned CONTEXT_SWITCH_CLK_SIZE    = 3;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StRun,
    StDone
  } loader_state_e;

  // Per-context PE configuration (ConfigData), broadcast to every PE.
  typedef struct packed {
    logic [NEIGHBOR_PE_NUM_BIT_LENGTH-1:0] input_pe_index_1;
    logic [NEIGHBOR_PE_NUM_BIT_LENGTH-1:0] input_pe_index_2;
    logic [OPERATION_BIT_LENGTH-1:0]       op;
    logic [DATA_WIDTH-1:0]                 const_data;
  } config_data_t;

  // Accepted config record: target context slot plus its payload.
  typedef struct packed {
    logic [CONTEXT_SIZE_BIT_LENGTH-1:0] context_id;
    config_data_t                       data;
  } config_record_t;

  // The id field may be wider than the number of implemented context slots.
  function automatic logic context_in_range(input logic [CONTEXT_SIZE_BIT_LENGTH-1:0] ctx);
    return 32'(ctx) < CONTEXT_SIZE;
  endfunction

endpackage

// File: rtl/cgra_context_timer.sv
// Slot timer, context counter and completed-iteration counter for a CGRA run.
module cgra_context_timer
  import cgra_config_loader_pkg::*;
#(
  parameter int unsigned ITERATION_BIT_LENGTH = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               clear,
  input  logic                               enable,
  input  logic [CONTEXT_SIZE_BIT_LENGTH-1:0] max_id,
  input  logic [ITERATION_BIT_LENGTH-1:0]    iterations,
  output logic [CONTEXT_SIZE_BIT_LENGTH-1:0] context_id,
  output logic [ITERATION_BIT_LENGTH-1:0]    iteration,
  output logic                               last
);

  localparam int unsigned SlotW =
      (CONTEXT_SWITCH_CLK_SIZE > 0) ? $clog2(CONTEXT_SWITCH_CLK_SIZE + 1) : 1;
  localparam logic [SlotW-1:0] SlotMax = SlotW'(CONTEXT_SWITCH_CLK_SIZE);
  localparam logic [SlotW-1:0] SlotOne = SlotW'(1);
  localparam logic [CONTEXT_SIZE_BIT_LENGTH-1:0] CtxOne = CONTEXT_SIZE_BIT_LENGTH'(1);
  localparam logic [ITERATION_BIT_LENGTH-1:0] IterOne = ITERATION_BIT_LENGTH'(1);

  logic [SlotW-1:0]                   slot_q;
  logic [CONTEXT_SIZE_BIT_LENGTH-1:0] ctx_q;
  logic [ITERATION_BIT_LENGTH-1:0]    iter_q;
  logic                               slot_wrap;
  logic                               ctx_wrap;

  assign slot_wrap  = (slot_q == SlotMax);
  assign ctx_wrap   = slot_wrap && (ctx_q == max_id);
  // Final cycle of the run: this wrap completes the last requested iteration.
  assign last       = enable && ctx_wrap && ((iter_q + IterOne) == iterations);
  assign context_id = ctx_q;
  assign iteration  = iter_q;

  // Advance slot every RUN cycle, context on slot wrap, iteration on context wrap.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      slot_q <= '0;
      ctx_q  <= '0;
      iter_q <= '0;
    end else if (enable) begin
      if (slot_wrap) begin
        slot_q <= '0;
        if (ctx_wrap) begin
          ctx_q  <= '0;
          iter_q <= iter_q + IterOne;
        end else begin
          ctx_q <= ctx_q + CtxOne;
        end
      end else begin
        slot_q <= slot_q + SlotOne;
      end
    end
  end

endmodule

// File: rtl/cgra_config_loader.sv
// Loads per-PE context configuration and sequences context execution runs.
module cgra_config_loader
  import cgra_config_loader_pkg::*;
#(
  parameter int unsigned PE_NUM               = 16,
  parameter int unsigned PE_ID_BIT_LENGTH     = 4,
  parameter int unsigned ITERATION_BIT_LENGTH = 16
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  cfg_valid,
  output logic                                  cfg_ready,
  input  logic [PE_ID_BIT_LENGTH-1:0]           cfg_pe_id,
  input  logic [CONTEXT_SIZE_BIT_LENGTH-1:0]    cfg_context_id,
  input  logic [NEIGHBOR_PE_NUM_BIT_LENGTH-1:0] cfg_input_PE_index_1,
  input  logic [NEIGHBOR_PE_NUM_BIT_LENGTH-1:0] cfg_input_PE_index_2,
  input  logic [OPERATION_BIT_LENGTH-1:0]       cfg_op,
  input  logic [DATA_WIDTH-1:0]                 cfg_const_data,
  input  logic                                  cmd_start,
  input  logic [CONTEXT_SIZE_BIT_LENGTH-1:0]    cmd_context_max_id,
  input  logic [ITERATION_BIT_LENGTH-1:0]       cmd_iterations,
  output logic [NEIGHBOR_PE_NUM_BIT_LENGTH-1:0] config_input_PE_index_1,
  output logic [NEIGHBOR_PE_NUM_BIT_LENGTH-1:0] config_input_PE_index_2,
  output logic [OPERATION_BIT_LENGTH-1:0]       config_op,
  output logic [DATA_WIDTH-1:0]                 config_const_data,
  output logic [CONTEXT_SIZE_BIT_LENGTH-1:0]    config_index,
  output logic [PE_NUM-1:0]                     write_config_data,
  output logic                                  start_exec,
  output logic [CONTEXT_SIZE_BIT_LENGTH-1:0]    mapping_context_max_id,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  cfg_error,
  output logic [CONTEXT_SIZE_BIT_LENGTH-1:0]    run_context_id,
  output logic [ITERATION_BIT_LENGTH-1:0]       run_iteration
);

  loader_state_e                      state_q;
  config_record_t                     cfg_record;
  config_record_t                     record_q;
  logic [PE_NUM-1:0]                  strobe_d;
  logic [PE_NUM-1:0]                  strobe_q;
  logic [CONTEXT_SIZE_BIT_LENGTH-1:0] max_id_q;
  logic [ITERATION_BIT_LENGTH-1:0]    iterations_q;
  logic                               start_exec_q;
  logic                               busy_q;
  logic                               done_q;
  logic                               error_q;
  logic                               cfg_fire;
  logic                               record_ok;
  logic                               cmd_accept;
  logic                               timer_enable;
  logic                               timer_last;

  // A pending run request takes priority over config traffic.
  assign cfg_ready  = (state_q == StIdle) && !cmd_start && !reset;
  assign cfg_fire   = cfg_valid && cfg_ready;
  assign cmd_accept = (state_q == StIdle) && cmd_start && !reset;
  assign record_ok  = context_in_range(cfg_context_id) && (32'(cfg_pe_id) < PE_NUM);

  assign cfg_record = '{
    context_id: cfg_context_id,
    data: '{
      input_pe_index_1: cfg_input_PE_index_1,
      input_pe_index_2: cfg_input_PE_index_2,
      op:               cfg_op,
      const_data:       cfg_const_data
    }
  };

  // One-hot write strobe for a valid accepted record.
  always_comb begin
    strobe_d = '0;
    for (int unsigned i = 0; i < PE_NUM; i++) begin
      strobe_d[i] = cfg_fire && record_ok && (32'(cfg_pe_id) == i);
    end
  end

  // Config path: register the record and strobe; bad records only raise the sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      record_q <= '0;
      strobe_q <= '0;
      error_q  <= 1'b0;
    end else begin
      strobe_q <= strobe_d;
      if (cfg_fire) begin
        if (record_ok) begin
          record_q <= cfg_record;
        end else begin
          error_q <= 1'b1;
        end
      end
    end
  end

  // Run-control FSM with registered Moore outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      max_id_q     <= '0;
      iterations_q <= '0;
      start_exec_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      start_exec_q <= 1'b0;
      done_q       <= 1'b0;
      case (state_q)
        StIdle: begin
          if (cmd_start) begin
            max_id_q     <= cmd_context_max_id;
            iterations_q <= cmd_iterations;
            if (cmd_iterations != '0) begin
              state_q      <= StStart;
              start_exec_q <= 1'b1;
              busy_q       <= 1'b1;
            end else begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end
          end
        end
        StStart: state_q <= StRun;
        StRun: begin
          if (timer_last) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign timer_enable = (state_q == StRun);

  cgra_context_timer #(
    .ITERATION_BIT_LENGTH(ITERATION_BIT_LENGTH)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .clear      (cmd_accept),
    .enable     (timer_enable),
    .max_id     (max_id_q),
    .iterations (iterations_q),
    .context_id (run_context_id),
    .iteration  (run_iteration),
    .last       (timer_last)
  );

  assign config_input_PE_index_1 = record_q.data.input_pe_index_1;
  assign config_input_PE_index_2 = record_q.data.input_pe_index_2;
  assign config_op               = record_q.data.op;
  assign config_const_data       = record_q.data.const_data;
  assign config_index            = record_q.context_id;
  assign write_config_data       = strobe_q;
  assign start_exec              = start_exec_q;
  assign mapping_context_max_id  = max_id_q;
  assign busy                    = busy_q;
  assign done                    = done_q;
  assign cfg_error               = error_q;

endmodule

// File: tb/tb_cgra_config_loader.sv
// Self-checking bench for cgra_config_loader: scoreboard of expected writes and runs.
module tb_cgra_config_loader;
  import cgra_config_loader_pkg::*;

  localparam int unsigned PeIdW      = 4;
  localparam int unsigned IterW      = 16;
  localparam int unsigned CtxW       = CONTEXT_SIZE_BIT_LENGTH;
  localparam int unsigned NbW        = NEIGHBOR_PE_NUM_BIT_LENGTH;
  localparam int unsigned OpW        = OPERATION_BIT_LENGTH;
  localparam int          SlotCycles = CONTEXT_SWITCH_CLK_SIZE + 1;

  typedef struct packed {
    logic [15:0]           strobe;
    logic [CtxW-1:0]       index;
    logic [OpW-1:0]        op;
    logic [NbW-1:0]        idx1;
    logic [NbW-1:0]        idx2;
    logic [DATA_WIDTH-1:0] cdata;
  } wr_exp_t;

  typedef struct {
    int iterations;
    int busy_cycles;
    int max_id;
  } run_exp_t;

  wr_exp_t  wr_q[$];
  run_exp_t run_q[$];
  int checks = 0;
  int passed = 0;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cfg_valid = 1'b0;
  logic [PeIdW-1:0] cfg_pe_id = '0;
  logic [CtxW-1:0] cfg_context_id = '0;
  logic [NbW-1:0] cfg_input_PE_index_1 = '0;
  logic [NbW-1:0] cfg_input_PE_index_2 = '0;
  logic [OpW-1:0] cfg_op = '0;
  logic [DATA_WIDTH-1:0] cfg_const_data = '0;
  logic cmd_start = 1'b0;
  logic [CtxW-1:0] cmd_context_max_id = '0;
  logic [IterW-1:0] cmd_iterations = '0;

  logic cfg_ready, start_exec, busy, done, cfg_error;
  logic [NbW-1:0] config_input_PE_index_1, config_input_PE_index_2;
  logic [OpW-1:0] config_op;
  logic [DATA_WIDTH-1:0] config_const_data;
  logic [CtxW-1:0] config_index, mapping_context_max_id, run_context_id;
  logic [15:0] write_config_data;
  logic [IterW-1:0] run_iteration;

  logic cfg_ready_12, start_exec_12, busy_12, done_12, cfg_error_12;
  logic [NbW-1:0] config_input_PE_index_1_12, config_input_PE_index_2_12;
  logic [OpW-1:0] config_op_12;
  logic [DATA_WIDTH-1:0] config_const_data_12;
  logic [CtxW-1:0] config_index_12, mapping_context_max_id_12, run_context_id_12;
  logic [11:0] write_config_data_12;
  logic [IterW-1:0] run_iteration_12;

  always #5 clk = ~clk;

  cgra_config_loader dut (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_pe_id(cfg_pe_id), .cfg_context_id(cfg_context_id),
    .cfg_input_PE_index_1(cfg_input_PE_index_1), .cfg_input_PE_index_2(cfg_input_PE_index_2),
    .cfg_op(cfg_op), .cfg_const_data(cfg_const_data), .cmd_start(cmd_start),
    .cmd_context_max_id(cmd_context_max_id), .cmd_iterations(cmd_iterations),
    .config_input_PE_index_1(config_input_PE_index_1),
    .config_input_PE_index_2(config_input_PE_index_2),
    .config_op(config_op), .config_const_data(config_const_data),
    .config_index(config_index), .write_config_data(write_config_data),
    .start_exec(start_exec), .mapping_context_max_id(mapping_context_max_id),
    .busy(busy), .done(done), .cfg_error(cfg_error),
    .run_context_id(run_context_id), .run_iteration(run_iteration)
  );

  cgra_config_loader #(.PE_NUM(12), .PE_ID_BIT_LENGTH(4), .ITERATION_BIT_LENGTH(16)) dut12 (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready_12),
    .cfg_pe_id(cfg_pe_id), .cfg_context_id(cfg_context_id),
    .cfg_input_PE_index_1(cfg_input_PE_index_1), .cfg_input_PE_index_2(cfg_input_PE_index_2),
    .cfg_op(cfg_op), .cfg_const_data(cfg_const_data), .cmd_start(cmd_start),
    .cmd_context_max_id(cmd_context_max_id), .cmd_iterations(cmd_iterations),
    .config_input_PE_index_1(config_input_PE_index_1_12),
    .config_input_PE_index_2(config_input_PE_index_2_12),
    .config_op(config_op_12), .config_const_data(config_const_data_12),
    .config_index(config_index_12), .write_config_data(write_config_data_12),
    .start_exec(start_exec_12), .mapping_context_max_id(mapping_context_max_id_12),
    .busy(busy_12), .done(done_12), .cfg_error(cfg_error_12),
    .run_context_id(run_context_id_12), .run_iteration(run_iteration_12)
  );

  // Scoreboard consumer: every strobe on the 16-PE instance must match the oldest expected write.
  always @(negedge clk) begin
    wr_exp_t obs;
    wr_exp_t exp_wr;
    if (!reset && write_config_data !== '0) begin
      obs = '{write_config_data, config_index, config_op, config_input_PE_index_1,
              config_input_PE_index_2, config_const_data};
      checks++;
      if (wr_q.size() == 0) begin
        $display("FAIL unexpected_strobe got %h want no write", obs);
      end else begin
        exp_wr = wr_q.pop_front();
        if (obs !== exp_wr) $display("FAIL write_record got %h want %h", obs, exp_wr);
        else passed++;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  // Drive a record and push the expected write for the 16-PE instance when it is valid.
  task automatic offer(input int pe, input int ctx, input int op, input int i1, input int i2,
                       input int d);
    wr_exp_t e;
    cfg_valid            = 1'b1;
    cfg_pe_id            = PeIdW'(pe);
    cfg_context_id       = CtxW'(ctx);
    cfg_op               = OpW'(op);
    cfg_input_PE_index_1 = NbW'(i1);
    cfg_input_PE_index_2 = NbW'(i2);
    cfg_const_data       = DATA_WIDTH'(d);
    if (ctx < int'(CONTEXT_SIZE)) begin
      e.strobe = 16'h0001 << pe;
      e.index  = CtxW'(ctx);
      e.op     = OpW'(op);
      e.idx1   = NbW'(i1);
      e.idx2   = NbW'(i2);
      e.cdata  = DATA_WIDTH'(d);
      wr_q.push_back(e);
    end
  endtask

  task automatic test_reset();
    offer(3, 1, 2, 1, 1, 16'h1111);
    void'(wr_q.pop_back());  // offered during reset: must never be written
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (cfg_ready !== 1'b0) $display("FAIL reset_cfg_ready got %b want 0", cfg_ready);
    else passed++;
    checks++;
    if ({busy, done, start_exec, cfg_error, write_config_data, config_index, config_op,
         mapping_context_max_id, run_context_id, run_iteration, config_const_data,
         cfg_error_12, write_config_data_12} !== '0)
      $display("FAIL reset_outputs got busy=%b done=%b wr=%h err=%b want all 0",
               busy, done, write_config_data, cfg_error);
    else passed++;
    @(negedge clk);
    reset = 1'b0;
    cfg_valid = 1'b0;
    #1;
    checks++;
    if (cfg_ready !== 1'b1) $display("FAIL idle_cfg_ready got %b want 1", cfg_ready);
    else passed++;
    @(negedge clk);
    checks++;
    if (write_config_data !== '0) $display("FAIL reset_no_write got %h want 0", write_config_data);
    else passed++;
  endtask

  task automatic test_single_record();
    @(negedge clk);
    offer(5, 2, 1, 0, 3, 16'hBEEF);
    #1;
    checks++;
    if (cfg_ready !== 1'b1) $display("FAIL single_ready got %b want 1", cfg_ready);
    else passed++;
    @(negedge clk);
    cfg_valid = 1'b0;
    checks++;
    if ({write_config_data, config_index, config_op} !== {16'h0020, 3'd2, 4'd1})
      $display("FAIL single_write got wr=%h idx=%0d op=%0d want wr=0020 idx=2 op=1",
               write_config_data, config_index, config_op);
    else passed++;
    @(negedge clk);
    checks++;
    if (write_config_data !== '0) $display("FAIL single_one_pulse got %h want 0", write_config_data);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int cnt = 0;
    @(negedge clk);
    offer(0, 0, 2, 1, 2, 16'h0001);
    @(negedge clk);
    offer(15, 5, 3, 3, 0, 16'h8000);
    cnt += int'(write_config_data != '0);
    @(negedge clk);
    offer(7, 3, 4, 2, 1, 16'h1357);
    cnt += int'(write_config_data != '0);
    @(negedge clk);
    cfg_valid = 1'b0;
    cnt += int'(write_config_data != '0);
    @(negedge clk);
    cnt += int'(write_config_data != '0);
    checks++;
    if (cnt != 3) $display("FAIL b2b_strobe_count got %0d want 3", cnt);
    else passed++;
    checks++;
    if (wr_q.size() != 0) $display("FAIL b2b_drained got %0d want 0", wr_q.size());
    else passed++;
  endtask

  task automatic test_run();
    int busy_cnt = 0;
    int se_cnt = 0;
    int t = 0;
    int seq_bad = 0;
    int cycles = 0;
    bit got_done = 0;
    run_exp_t e;
    @(negedge clk);
    cmd_start = 1'b1;
    cmd_context_max_id = 3'd2;
    cmd_iterations = 16'd3;
    run_q.push_back('{3, 1 + 3 * 3 * SlotCycles, 2});
    #1;
    checks++;
    if (cfg_ready !== 1'b0) $display("FAIL run_blocks_cfg got %b want 0", cfg_ready);
    else passed++;
    @(negedge clk);
    cmd_start = 1'b0;
    e = run_q.pop_front();
    while (!got_done && cycles < 500) begin
      if (done === 1'b1) begin
        got_done = 1;
      end else begin
        busy_cnt += int'(busy);
        se_cnt += int'(start_exec);
        if (busy && !start_exec) begin
          if (run_context_id !== CtxW'((t / SlotCycles) % (e.max_id + 1)) ||
              run_iteration !== IterW'(t / (SlotCycles * (e.max_id + 1))))
            seq_bad++;
          t++;
        end
        @(negedge clk);
        cycles++;
      end
    end
    checks++;
    if (!got_done) $display("FAIL run_done_seen got timeout want done");
    else passed++;
    checks++;
    if (busy_cnt != e.busy_cycles) $display("FAIL run_busy_len got %0d want %0d", busy_cnt, e.busy_cycles);
    else passed++;
    checks++;
    if (se_cnt != 1) $display("FAIL run_start_exec got %0d want 1", se_cnt);
    else passed++;
    checks++;
    if (seq_bad != 0) $display("FAIL run_context_seq got %0d bad cycles want 0", seq_bad);
    else passed++;
    checks++;
    if ({busy, run_iteration} !== {1'b0, IterW'(e.iterations)})
      $display("FAIL run_final got busy=%b iter=%0d want busy=0 iter=%0d", busy, run_iteration,
               e.iterations);
    else passed++;
    @(negedge clk);
    checks++;
    if ({done, run_iteration, mapping_context_max_id} !==
        {1'b0, IterW'(e.iterations), CtxW'(e.max_id)})
      $display("FAIL run_after_done got done=%b iter=%0d max=%0d want 0 %0d %0d", done,
               run_iteration, mapping_context_max_id, e.iterations, e.max_id);
    else passed++;
  endtask

  task automatic test_zero_iter();
    @(negedge clk);
    cmd_start = 1'b1;
    cmd_context_max_id = 3'd1;
    cmd_iterations = 16'd0;
    @(negedge clk);
    cmd_start = 1'b0;
    checks++;
    if ({done, start_exec, busy, run_iteration} !== {1'b1, 1'b0, 1'b0, 16'd0})
      $display("FAIL zero_done got done=%b se=%b busy=%b iter=%0d want 1 0 0 0", done,
               start_exec, busy, run_iteration);
    else passed++;
    @(negedge clk);
    #1;
    checks++;
    if ({done, busy, cfg_ready} !== 3'b001)
      $display("FAIL zero_back_idle got done=%b busy=%b rdy=%b want 0 0 1", done, busy, cfg_ready);
    else passed++;
  endtask

  task automatic test_collision();
    int early = 0;
    int cycles = 0;
    bit got_done = 0;
    @(negedge clk);
    offer(9, 4, 6, 1, 1, 16'hA5A5);
    cmd_start = 1'b1;
    cmd_context_max_id = 3'd0;
    cmd_iterations = 16'd2;
    #1;
    checks++;
    if (cfg_ready !== 1'b0) $display("FAIL collide_ready got %b want 0", cfg_ready);
    else passed++;
    @(negedge clk);
    cmd_start = 1'b0;
    while (!got_done && cycles < 200) begin
      if (write_config_data !== '0 || cfg_ready !== 1'b0) early++;
      if (done === 1'b1) got_done = 1;
      else begin
        @(negedge clk);
        cycles++;
      end
    end
    checks++;
    if (!got_done || early != 0)
      $display("FAIL collide_held got done=%0d early=%0d want done=1 early=0", got_done, early);
    else passed++;
    @(negedge clk);
    checks++;
    if (cfg_ready !== 1'b1) $display("FAIL collide_idle_ready got %b want 1", cfg_ready);
    else passed++;
    @(negedge clk);
    cfg_valid = 1'b0;
    checks++;
    if (write_config_data !== 16'h0200)
      $display("FAIL collide_accept got %h want 0200", write_config_data);
    else passed++;
  endtask

  task automatic test_reset_mid_run();
    int cycles = 0;
    int stray = 0;
    int busy_cnt = 0;
    bit got_done = 0;
    run_exp_t e;
    @(negedge clk);
    cmd_start = 1'b1;
    cmd_context_max_id = 3'd2;
    cmd_iterations = 16'd2;
    @(negedge clk);
    cmd_start = 1'b0;
    while (run_context_id !== 3'd1 && cycles < 100) begin
      @(negedge clk);
      cycles++;
    end
    checks++;
    if (run_context_id !== 3'd1 || busy !== 1'b1)
      $display("FAIL midrun_reached got ctx=%0d busy=%b want 1 1", run_context_id, busy);
    else passed++;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done, start_exec, mapping_context_max_id, run_context_id, run_iteration} !== '0)
      $display("FAIL midrun_outputs got busy=%b done=%b ctx=%0d iter=%0d max=%0d want 0",
               busy, done, run_context_id, run_iteration, mapping_context_max_id);
    else passed++;
    reset = 1'b0;
    #1;
    checks++;
    if (cfg_ready !== 1'b1) $display("FAIL midrun_idle got %b want 1", cfg_ready);
    else passed++;
    repeat (6) begin
      @(negedge clk);
      stray += int'(done) + int'(busy);
    end
    checks++;
    if (stray != 0) $display("FAIL midrun_no_done got %0d want 0", stray);
    else passed++;
    cmd_start = 1'b1;
    cmd_context_max_id = 3'd1;
    cmd_iterations = 16'd1;
    run_q.push_back('{1, 1 + 1 * 2 * SlotCycles, 1});
    @(negedge clk);
    cmd_start = 1'b0;
    e = run_q.pop_front();
    cycles = 0;
    while (!got_done && cycles < 200) begin
      if (done === 1'b1) got_done = 1;
      else begin
        busy_cnt += int'(busy);
        @(negedge clk);
        cycles++;
      end
    end
    checks++;
    if (!got_done || busy_cnt != e.busy_cycles || run_iteration !== IterW'(e.iterations))
      $display("FAIL rerun got done=%0d busy=%0d iter=%0d want 1 %0d %0d", got_done, busy_cnt,
               run_iteration, e.busy_cycles, e.iterations);
    else passed++;
  endtask

  task automatic test_bad_record();
    @(negedge clk);
    offer(13, 1, 2, 0, 1, 16'h0D0D);
    @(negedge clk);
    cfg_valid = 1'b0;
    checks++;
    if ({write_config_data_12, cfg_error_12} !== {12'h000, 1'b1})
      $display("FAIL pe12_bad got wr=%h err=%b want 000 1", write_config_data_12, cfg_error_12);
    else passed++;
    checks++;
    if (cfg_error !== 1'b0) $display("FAIL pe16_no_error got %b want 0", cfg_error);
    else passed++;
    offer(2, 7, 1, 1, 1, 16'h7777);
    @(negedge clk);
    cfg_valid = 1'b0;
    checks++;
    if (cfg_error !== 1'b1) $display("FAIL ctx_error got %b want 1", cfg_error);
    else passed++;
    repeat (3) @(negedge clk);
    checks++;
    if ({cfg_error, cfg_error_12} !== 2'b11)
      $display("FAIL error_sticky got %b%b want 11", cfg_error, cfg_error_12);
    else passed++;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({cfg_error, cfg_error_12} !== 2'b00)
      $display("FAIL error_cleared got %b%b want 00", cfg_error, cfg_error_12);
    else passed++;
    checks++;
    if (wr_q.size() != 0) $display("FAIL sb_empty got %0d pending want 0", wr_q.size());
    else passed++;
  endtask

  initial begin
    test_reset();
    test_single_record();
    test_back_to_back();
    test_run();
    test_zero_iter();
    test_collision();
    test_reset_mid_run();
    test_bad_record();
    @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
